iter_shift_unit: RTL and testbench
==================================

// Module: iter_shift_unit
// PURPOSE
//  Iterative, parametrised shift/rotate unit for the processor execute stage; replaces fixed-amount shift wiring.
//  Supports SLL/SRL/SRA/ROR by a variable amount, one log2 stage (shift by 2^k) per clock.
//  Valid/ready handshake on both sides; sits beside multdiv as a multi-cycle ALU side unit.
// PARAMETERS
//  WIDTH    32               operand width; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)    localparam, shift-amount width = number of stages
// PORTS
//  clock     in   1        single clock, rising edge
//  reset     in   1        asynchronous, active-high
//  in_valid  in   1        request present
//  in_ready  out  1        unit can accept request
//  op        in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (right rotate)
//  data_in   in   WIDTH    operand
//  shamt     in   SHAMT_W  shift amount, unsigned 0..WIDTH-1
//  out_valid out  1        result present
//  out_ready in   1        consumer accepts result
//  data_out  out  WIDTH    result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, stage k=0, acc=0, out_valid=0, data_out=0; in_ready=0 while reset high.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE) & ~reset.
//  - IDLE: on in_valid&in_ready capture data_in->acc, op, shamt, sign=data_in[WIDTH-1]; k=0; go SHIFT.
//  - SHIFT: each cycle acc <= shamt[k] ? stage(acc, op, 2^k) : acc; k++; after stage SHAMT_W-1 go DONE.
//  - Stage fill: SLL/SRL zero fill; SRA fill with captured sign (not current acc MSB); ROR wraps low bits to top.
//  - DONE: out_valid=1, data_out=acc, held stable until out_ready; on out_valid&out_ready go IDLE.
//  - Latency (fixed): accept edge +SHAMT_W edges -> out_valid high; WIDTH=32 -> 5 cycles.
//  - Throughput: no overlap; next accept earliest cycle after result handshake (SHAMT_W+2 cycles/op).
//  - in_valid outside IDLE ignored; inputs sampled only at accept edge (may change during SHIFT).
//  - shamt=0: result equals data_in for every op, same latency.
//  - Reset mid-SHIFT or mid-DONE: operation discarded, no out_valid pulse.
//  - data_out outside DONE holds last result (0 after reset); not meaningful unless out_valid.
// CONFIGURATION
//  - SHIFT_EARLY_DONE_EN defined: SHIFT exits to DONE after stage k when shamt bits above k are all zero;
//    latency = max(1, msb_index(shamt)+1) cycles; shamt=0 -> 1 cycle.
//  - Not defined: fixed SHAMT_W-cycle latency for all shamt (deterministic timing).
//  - Result values identical in both builds.
// STRUCTURE
//  - Package shift_pkg: op encodings (OP_SLL/OP_SRL/OP_SRA/OP_ROR), FSM state encoding (ST_IDLE/ST_SHIFT/ST_DONE).
//  - Sub-module shift_stage #(WIDTH): combinational; inputs acc, op, sign, amount index k; output shifted by 2^k.
//  - Top holds FSM, stage counter, captured op/shamt/sign, acc register, handshake logic.
// TESTING
//  1. SRA 0x80000000 shamt=2 -> 0xE0000000; out_valid exactly 5 cycles after accept (early-done off).
//  2. SRL 0x80000000 shamt=31 -> 0x00000001; SLL 0x00000001 shamt=31 -> 0x80000000; SRA 0x7FFFFFFF shamt=31 -> 0.
//  3. ROR 0x12345678 shamt=4 -> 0x81234567; ROR 0x00000001 shamt=1 -> 0x80000000; any op shamt=0 -> data_in.
//  4. Backpressure: out_ready low 3 cycles in DONE -> data_out/out_valid stable, in_ready=0, in_valid ignored.
//  5. Reset asserted mid-SHIFT -> out_valid=0 immediately, in_ready=1 first cycle after deassert, next op correct.
//  6. SHIFT_EARLY_DONE_EN: SRL 0xF0 shamt=2 -> 0x3C after 2 cycles; shamt=0 -> 1 cycle; shamt=16 -> 5 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_pkg
// Brief   : Operation and FSM state encodings shared by the iterative shifter.
// Revision: 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : shift_stage
// Brief   : Combinational single log2 stage: shifts/rotates i_acc by 2^i_k.
// Revision: 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         i_acc,
    input  op_e                      i_op,
    input  logic                     i_sign,
    input  logic [$clog2(WIDTH)-1:0] i_k,
    output logic [WIDTH-1:0]         o_result
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0][WIDTH-1:0] w_cand;

    // Every stage candidate is a constant-distance rewire; i_k only picks one.
    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
        localparam int S = 1 << j;
        // SRA fills with the operand sign captured at accept, not the live MSB.
        assign w_cand[j] = (i_op == OP_SLL) ? {i_acc[WIDTH-1-S:0], {S{1'b0}}}     :
                           (i_op == OP_SRL) ? {{S{1'b0}}, i_acc[WIDTH-1:S]}       :
                           (i_op == OP_SRA) ? {{S{i_sign}}, i_acc[WIDTH-1:S]}     :
                                              {i_acc[S-1:0], i_acc[WIDTH-1:S]};
    end

    always_comb begin
        o_result = i_acc;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (i_k == i[SHAMT_W-1:0]) begin
                o_result = w_cand[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module  : iter_shift_unit
// Brief   : Iterative SLL/SRL/SRA/ROR unit, one log2 stage per clock, with
//           valid/ready handshakes. Optional macro SHIFT_EARLY_DONE_EN ends
//           the iteration once no higher shamt bits remain.
// Revision: 1.0 - initial release
// ============================================================================
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out
);

    localparam int                 SHAMT_W  = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] C_K_LAST = SHAMT_W'(SHAMT_W - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [SHAMT_W-1:0] r_k;
    logic [SHAMT_W-1:0] r_shamt;
    op_e                r_op;
    logic               r_sign;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_stage_out;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_accept;
    logic               w_stage_exit;

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_acc    (r_acc),
        .i_op     (r_op),
        .i_sign   (r_sign),
        .i_k      (r_k),
        .o_result (w_stage_out)
    );

    assign w_acc_nxt = r_shamt[r_k] ? w_stage_out : r_acc;

`ifdef SHIFT_EARLY_DONE_EN
    assign w_stage_exit = (r_k == C_K_LAST) || ((r_shamt >> (r_k + 1'b1)) == '0);
`else
    assign w_stage_exit = (r_k == C_K_LAST);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = ~reset;
                if (in_valid && !reset) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_stage_exit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_result is a separate copy so data_out keeps the last answer while
    // r_acc is reloaded by the next request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_k      <= '0;
            r_op     <= OP_SLL;
            r_shamt  <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc   <= data_in;
            r_op    <= op_e'(op);
            r_shamt <= shamt;
            r_sign  <= data_in[WIDTH-1];
            r_k     <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_acc <= w_acc_nxt;
            if (w_stage_exit) begin
                r_k      <= '0;
                r_result <= w_acc_nxt;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign data_out = r_result;

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_iter_shift_unit
// Brief   : Self-checking bench for iter_shift_unit (WIDTH=32).
// Revision: 1.0 - initial release
// ============================================================================
module tb_iter_shift_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd0;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_out;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    iter_shift_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data_in   (data_in),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
        logic [63:0] dd;
        case (o)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return $signed(d) >>> s;
            default: begin
                dd = {d, d} >> s;
                return dd[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
        int msb;
        msb = 0;
        for (int i = 0; i < 5; i++) if (s[i]) msb = i;
`ifdef SHIFT_EARLY_DONE_EN
        return msb + 1;
`else
        return (msb >= 0) ? 5 : 0;
`endif
    endfunction

    // Scoreboard: predicts each accepted request and checks result and latency.
    logic        exp_pend = 1'b0;
    logic        seen     = 1'b0;
    logic [31:0] exp_data = '0;
    int          exp_acc_cyc = 0;
    int          exp_lat_c   = 0;

    always @(negedge clock) begin
        if (reset) begin
            exp_pend = 1'b0;
            seen     = 1'b0;
        end else begin
            if (out_valid) begin
                if (!exp_pend) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("model_data", data_out, exp_data);
                    if (!seen) check("latency", cyc - exp_acc_cyc, exp_lat_c);
                    seen = 1'b1;
                    if (out_ready) exp_pend = 1'b0;
                end
                check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_pend    = 1'b1;
                seen        = 1'b0;
                exp_data    = model(op, data_in, int'(shamt));
                exp_acc_cyc = cyc + 1;
                exp_lat_c   = exp_lat(shamt);
            end
        end
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] d;
        logic [4:0]  s;
        logic [31:0] e;
        int          bp;
    } vec_t;

    vec_t vecs [17] = '{
        '{2'd2, 32'h80000000, 5'd2,  32'hE0000000, 0},
        '{2'd1, 32'h80000000, 5'd31, 32'h00000001, 0},
        '{2'd0, 32'h00000001, 5'd31, 32'h80000000, 0},
        '{2'd2, 32'h7FFFFFFF, 5'd31, 32'h00000000, 0},
        '{2'd3, 32'h12345678, 5'd4,  32'h81234567, 3},
        '{2'd3, 32'h00000001, 5'd1,  32'h80000000, 0},
        '{2'd0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0},
        '{2'd1, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0},
        '{2'd2, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0},
        '{2'd3, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0},
        '{2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0},
        '{2'd0, 32'h0000F00F, 5'd8,  32'h00F00F00, 0},
        '{2'd1, 32'h000000F0, 5'd2,  32'h0000003C, 0},
        '{2'd1, 32'h80000000, 5'd16, 32'h00008000, 0},
        '{2'd2, 32'h80000010, 5'd5,  32'hFC000000, 0},
        '{2'd3, 32'h80000001, 5'd31, 32'h00000003, 0},
        '{2'd2, 32'hC0000000, 5'd3,  32'hF8000000, 0}
    };

    // Called at posedge+1 with the unit idle.
    task automatic run_op(input vec_t v);
        int          waitc;
        logic [31:0] held;
        in_valid  = 1'b1;
        op        = v.o;
        data_in   = v.d;
        shamt     = v.s;
        out_ready = (v.bp == 0);
        @(posedge clock); #1;
        // Inputs scrambled while busy; the unit must ignore them.
        data_in = $urandom;
        shamt   = 5'($urandom);
        op      = 2'($urandom);
        waitc   = 0;
        while (!out_valid && waitc < 40) begin
            @(posedge clock); #1;
            waitc++;
        end
        if (!out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            check("result_literal", data_out, v.e);
            held = data_out;
            repeat (v.bp) begin
                @(posedge clock); #1;
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                check("bp_data_hold", data_out, held);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clock); #1;
            check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
            check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
            check("post_hs_data_hold", data_out, v.e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in the middle of SHIFT.
        in_valid = 1'b1; op = 2'd1; data_in = 32'hA5A5A5A5; shamt = 5'd7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("rst_shift_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_shift_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("rst_shift_rel_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) begin
            @(posedge clock); #1;
            check("rst_shift_no_pulse", {31'd0, out_valid}, 32'd0);
        end

        // Reset while holding a result in DONE.
        v = '{2'd0, 32'h00000003, 5'd1, 32'h00000006, 0};
        in_valid = 1'b1; op = v.o; data_in = v.d; shamt = v.s; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clock); #1; end
        check("done_before_rst", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done_data_out", data_out, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;

        run_op('{2'd2, 32'h90000000, 5'd4, 32'hF9000000, 0});
        run_op('{2'd3, 32'hCAFEF00D, 5'd16, 32'hF00DCAFE, 0});

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
